// File: rtl/traffic_phase_scheduler_pkg.sv
// Shared encodings for the intersection phase scheduler: light codes, sensor
// codes, FSM states and the sensor-to-density mapping.
package traffic_phase_scheduler_pkg;

  typedef enum logic [1:0] {
    LIGHT_RED    = 2'd0,
    LIGHT_YELLOW = 2'd1,
    LIGHT_GREEN  = 2'd2
  } light_t;

  localparam logic [2:0] SENSOR_EMPTY = 3'b000;
  localparam logic [2:0] SENSOR_LESS  = 3'b001;
  localparam logic [2:0] SENSOR_MORE  = 3'b011;
  localparam logic [2:0] SENSOR_FULL  = 3'b111;

  typedef enum logic [1:0] {
    ST_ALL_RED = 2'd0,
    ST_GREEN   = 2'd1,
    ST_YELLOW  = 2'd2
  } state_t;

  // Broken (non-thermometer) sensor patterns are treated as a full road.
  function automatic logic [1:0] density_level(input logic [2:0] s);
    logic [1:0] lvl;
    case (s)
      SENSOR_EMPTY: lvl = 2'd0;
      SENSOR_LESS:  lvl = 2'd1;
      SENSOR_MORE:  lvl = 2'd2;
      SENSOR_FULL:  lvl = 2'd3;
      default:      lvl = 2'd3;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/traffic_phase_scheduler_road_select.sv
// Combinational arbiter: emergency requests first (lowest index), otherwise the
// busiest not-yet-served road this round, ties to the lowest index.
module traffic_phase_scheduler_road_select
  import traffic_phase_scheduler_pkg::*;
(
  input  logic [3:0][1:0] levels,
  input  logic [3:0]      served,
  input  logic [3:0]      emg_req,
  output logic [3:0]      grant,
  output logic [1:0]      level,
  output logic            round_wrap
);

  logic [3:0] nonempty;
  logic [3:0] cand;
  logic       found;

  always_comb begin
    grant      = '0;
    level      = '0;
    round_wrap = 1'b0;
    found      = 1'b0;
    nonempty   = '0;
    cand       = '0;
    for (int i = 0; i < 4; i++) nonempty[i] = (levels[i] != 2'd0);

    if (emg_req != 4'b0000) begin
      for (int i = 0; i < 4; i++) begin
        if (emg_req[i] && !found) begin
          found    = 1'b1;
          grant[i] = 1'b1;
          level    = levels[i];
        end
      end
    end else begin
      cand = ~served & nonempty;
      // Every busy road has had its turn: start a fresh round.
      if (cand == 4'b0000 && nonempty != 4'b0000) begin
        round_wrap = 1'b1;
        cand       = nonempty;
      end
      for (int i = 0; i < 4; i++) begin
        if (cand[i] && (!found || levels[i] > level)) begin
          found = 1'b1;
          grant = '0;
          grant[i] = 1'b1;
          level = levels[i];
        end
      end
    end
  end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Density-weighted four-road phase scheduler: GREEN -> YELLOW -> ALL_RED cycling,
// busiest road first each round, with emergency preemption and green hold.
module traffic_phase_scheduler
  import traffic_phase_scheduler_pkg::*;
#(
  parameter int G_BASE  = 2,
  parameter int G_STEP  = 2,
  parameter int Y_TIME  = 3,
  parameter int AR_TIME = 1,
  parameter int CW      = 5
) (
  input  logic          clock,
  input  logic          clear_n,
  input  logic [2:0]    S1,
  input  logic [2:0]    S2,
  input  logic [2:0]    S3,
  input  logic [2:0]    S4,
  input  logic [3:0]    emg_req,
  output logic [1:0]    T1,
  output logic [1:0]    T2,
  output logic [1:0]    T3,
  output logic [1:0]    T4,
  output logic [3:0]    grant,
  output logic [3:0]    served,
  output logic [CW-1:0] phase_timer
);

  localparam logic [CW-1:0] Y_LOAD  = CW'(Y_TIME - 1);
  localparam logic [CW-1:0] AR_LOAD = CW'(AR_TIME - 1);

  function automatic logic [CW-1:0] green_load(input logic [1:0] lvl);
    return CW'(G_BASE + G_STEP * int'(lvl) - 1);
  endfunction

  state_t          state_q, state_d;
  logic [CW-1:0]   timer_d;
  logic [3:0]      grant_d, served_d;
  logic [3:0][1:0] lights_q, lights_d;
  logic [3:0][1:0] levels;
  logic [3:0]      sel_grant;
  logic [1:0]      sel_level;
  logic            sel_wrap;

  assign levels = {density_level(S4), density_level(S3),
                   density_level(S2), density_level(S1)};

  traffic_phase_scheduler_road_select u_road_select (
    .levels     (levels),
    .served     (served),
    .emg_req    (emg_req),
    .grant      (sel_grant),
    .level      (sel_level),
    .round_wrap (sel_wrap)
  );

  always_comb begin
    state_d  = state_q;
    timer_d  = phase_timer - 1'b1;
    grant_d  = grant;
    served_d = served;
    lights_d = '0;

    case (state_q)
      ST_ALL_RED: begin
        if (phase_timer == '0) begin
          if (sel_grant != 4'b0000) begin
            state_d  = ST_GREEN;
            grant_d  = sel_grant;
            served_d = (sel_wrap ? 4'b0000 : served) | sel_grant;
            timer_d  = green_load(sel_level);
          end else begin
            timer_d = '0;
          end
        end
      end
      ST_GREEN: begin
        if ((emg_req & ~grant) != 4'b0000) begin
          state_d = ST_YELLOW;
          timer_d = Y_LOAD;
        end else if ((emg_req & grant) != 4'b0000) begin
          timer_d = phase_timer;
        end else if (phase_timer == '0) begin
          state_d = ST_YELLOW;
          timer_d = Y_LOAD;
        end
      end
      ST_YELLOW: begin
        if (phase_timer == '0) begin
          state_d = ST_ALL_RED;
          timer_d = AR_LOAD;
          grant_d = '0;
        end
      end
      default: begin
        state_d = ST_ALL_RED;
        timer_d = AR_LOAD;
        grant_d = '0;
      end
    endcase

    for (int i = 0; i < 4; i++) begin
      if (grant_d[i] && state_d == ST_GREEN)       lights_d[i] = LIGHT_GREEN;
      else if (grant_d[i] && state_d == ST_YELLOW) lights_d[i] = LIGHT_YELLOW;
      else                                         lights_d[i] = LIGHT_RED;
    end
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q     <= ST_ALL_RED;
      phase_timer <= AR_LOAD;
      grant       <= '0;
      served      <= '0;
      lights_q    <= '0;
    end else begin
      state_q     <= state_d;
      phase_timer <= timer_d;
      grant       <= grant_d;
      served      <= served_d;
      lights_q    <= lights_d;
    end
  end

  assign T1 = lights_q[0];
  assign T2 = lights_q[1];
  assign T3 = lights_q[2];
  assign T4 = lights_q[3];

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler: expected grants (road, served mask,
// green length) are queued by the stimulus and checked by a phase monitor.
module tb_traffic_phase_scheduler;

  logic       clock;
  logic       clear_n;
  logic [2:0] S1, S2, S3, S4;
  logic [3:0] emg_req;
  logic [1:0] T1, T2, T3, T4;
  logic [3:0] grant;
  logic [3:0] served;
  logic [4:0] phase_timer;

  typedef struct {
    logic [3:0] g;
    logic [3:0] srv;
    int         len;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  traffic_phase_scheduler dut (
    .clock       (clock),
    .clear_n     (clear_n),
    .S1          (S1),
    .S2          (S2),
    .S3          (S3),
    .S4          (S4),
    .emg_req     (emg_req),
    .T1          (T1),
    .T2          (T2),
    .T3          (T3),
    .T4          (T4),
    .grant       (grant),
    .served      (served),
    .phase_timer (phase_timer)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic push(input logic [3:0] g, input logic [3:0] srv, input int len);
    exp_t e;
    e.g = g; e.srv = srv; e.len = len;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  function automatic logic [1:0] light_of(input logic [3:0] g, input logic [3:0][1:0] tl);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (g[i]) r = tl[i];
    return r;
  endfunction

  // Phase monitor: pops one expectation per new grant and times green/yellow.
  logic [3:0] prev_grant = '0;
  int         gcnt = 0, ycnt = 0, cur_len = -1;

  always @(negedge clock) begin
    logic [3:0][1:0] tl;
    logic            bad;
    logic [1:0]      lt;
    exp_t            it;
    tl = {T4, T3, T2, T1};
    if (!clear_n) begin
      prev_grant = '0; gcnt = 0; ycnt = 0; cur_len = -1;
    end else begin
      bad = 1'b0;
      for (int i = 0; i < 4; i++)
        if ((tl[i] != 2'd0 && !grant[i]) || tl[i] > 2'd2) bad = 1'b1;
      check("lights_vs_grant", {31'd0, bad}, 32'd0);

      if (grant != 4'b0000 && prev_grant == 4'b0000) begin
        if (exp_q.size() == 0) begin
          check("unexpected_grant", {28'd0, grant}, 32'd0);
          cur_len = -1;
        end else begin
          it = exp_q.pop_front();
          check("grant_road", {28'd0, grant}, {28'd0, it.g});
          check("grant_served", {28'd0, served}, {28'd0, it.srv});
          cur_len = it.len;
        end
        gcnt = 0; ycnt = 0;
      end
      lt = light_of(grant, tl);
      if (grant != 4'b0000 && lt == 2'd2) gcnt++;
      if (grant != 4'b0000 && lt == 2'd1) begin
        if (ycnt == 0 && cur_len >= 0) check("green_len", gcnt, cur_len);
        ycnt++;
      end
      if (grant == 4'b0000 && prev_grant != 4'b0000) check("yellow_len", ycnt, 3);
      prev_grant = grant;
    end
  end

  initial begin
    clear_n = 1'b0;
    emg_req = 4'b0000;
    S1 = 3'b111; S2 = 3'b001; S3 = 3'b011; S4 = 3'b000;
    cyc(2);
    check("rst_lights", {24'd0, T4, T3, T2, T1}, 32'd0);
    check("rst_grant", {28'd0, grant}, 32'd0);
    check("rst_served", {28'd0, served}, 32'd0);
    check("rst_timer", {27'd0, phase_timer}, 32'd0);

    // Priority order, then wrap back to road 1
    push(4'b0001, 4'b0001, 8);
    push(4'b0100, 4'b0101, 6);
    push(4'b0010, 4'b0111, 4);
    push(4'b0001, 4'b0001, 8);
    clear_n = 1'b1;
    cyc(40);
    S1 = 3'b000; S2 = 3'b000; S3 = 3'b000; S4 = 3'b000;
    cyc(5);
    check("idle_grant", {28'd0, grant}, 32'd0);
    check("idle_timer", {27'd0, phase_timer}, 32'd0);
    check("idle_lights", {24'd0, T4, T3, T2, T1}, 32'd0);

    // Wake from idle on road 2
    push(4'b0010, 4'b0011, 6);
    S2 = 3'b011;
    cyc(1);
    check("wake_grant", {28'd0, grant}, 32'd2);
    check("wake_T2", {30'd0, T2}, 32'd2);
    check("wake_timer", {27'd0, phase_timer}, 32'd5);
    cyc(7);
    check("pre_rst_T2", {30'd0, T2}, 32'd1);
    clear_n = 1'b0;
    #1;
    check("midrst_lights", {24'd0, T4, T3, T2, T1}, 32'd0);
    check("midrst_served", {28'd0, served}, 32'd0);
    check("midrst_grant", {28'd0, grant}, 32'd0);

    // Ties: all roads at level 1
    S1 = 3'b001; S2 = 3'b001; S3 = 3'b001; S4 = 3'b001;
    push(4'b0001, 4'b0001, 4);
    push(4'b0010, 4'b0011, 4);
    push(4'b0100, 4'b0111, 4);
    push(4'b1000, 4'b1111, 4);
    cyc(1);
    clear_n = 1'b1;
    cyc(30);
    clear_n = 1'b0;

    // Invalid sensor code on road 4 counts as full
    S4 = 3'b101;
    push(4'b1000, 4'b1000, 8);
    push(4'b0001, 4'b1001, 4);
    cyc(1);
    clear_n = 1'b1;
    cyc(18);
    clear_n = 1'b0;

    // Emergency preemption and green hold
    S1 = 3'b111; S2 = 3'b000; S3 = 3'b011; S4 = 3'b000;
    push(4'b0001, 4'b0001, 3);
    push(4'b0100, 4'b0101, 10);
    push(4'b0001, 4'b0001, 8);
    cyc(1);
    clear_n = 1'b1;
    cyc(3);
    check("emg_pre_timer", {27'd0, phase_timer}, 32'd5);
    emg_req = 4'b0100;
    cyc(1);
    check("emg_T1_yellow", {30'd0, T1}, 32'd1);
    cyc(4);
    check("emg_grant", {28'd0, grant}, 32'd4);
    check("emg_T3_green", {30'd0, T3}, 32'd2);
    cyc(2);
    check("emg_hold_a", {27'd0, phase_timer}, 32'd5);
    cyc(2);
    check("emg_hold_b", {27'd0, phase_timer}, 32'd5);
    emg_req = 4'b0000;
    cyc(1);
    check("emg_release", {27'd0, phase_timer}, 32'd4);
    cyc(18);
    S1 = 3'b000; S3 = 3'b000;
    cyc(6);
    check("end_grant", {28'd0, grant}, 32'd0);
    check("queue_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
